// File: rtl/bus_arb_ctrl.sv
// bus_arb_ctrl: shares one external word bus between an instruction-fetch
// port and a load/store port. Load/store has fixed priority over fetch.
// Each access runs IDLE -> ACC -> DONE. A wait-state counter ends an
// access that never sees bus_rdy_, returns zero data and pulses bus_err.

module bus_arb_ctrl #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int TMO_W  = 4
) (
    input  logic              clk,
    input  logic              reset_,
    // fetch port
    input  logic              if_req_,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rd_data,
    output logic              if_busy,
    // load/store port
    input  logic              mem_as_,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_busy,
    // external bus
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

    // Counter value one below the all-ones limit: one more wait cycle here
    // means the limit is reached and the access is abandoned.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t           state;
    owner_t           owner;
    logic [TMO_W-1:0] tmo_cnt;

    // Arbitration FSM together with the registered bus and read-data outputs.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            tmo_cnt     <= '0;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            bus_err     <= 1'b0;
            if_rd_data  <= '0;
            mem_rd_data <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mem_as_) begin
                        bus_as_     <= 1'b0;
                        bus_rw      <= mem_rw;
                        bus_addr    <= mem_addr;
                        bus_wr_data <= mem_wr_data;
                        owner       <= OWN_MEM;
                        tmo_cnt     <= '0;
                        state       <= ACC;
                    end else if (!if_req_) begin
                        bus_as_  <= 1'b0;
                        bus_rw   <= 1'b1;
                        bus_addr <= if_addr;
                        owner    <= OWN_IF;
                        tmo_cnt  <= '0;
                        state    <= ACC;
                    end
                end

                ACC: begin
                    if (!bus_rdy_) begin
                        bus_as_ <= 1'b1;
                        state   <= DONE;
                        if (owner == OWN_MEM) begin
                            mem_rd_data <= bus_rw ? bus_rd_data : '0;
                        end else if (owner == OWN_IF) begin
                            if_rd_data <= bus_rw ? bus_rd_data : '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (tmo_cnt == TMO_LAST) begin
                            bus_as_ <= 1'b1;
                            bus_err <= 1'b1;
                            state   <= DONE;
                            if (owner == OWN_MEM) begin
                                mem_rd_data <= '0;
                            end else if (owner == OWN_IF) begin
                                if_rd_data <= '0;
                            end
                        end
                    end
                end

                DONE: begin
                    owner <= OWN_NONE;
                    state <= IDLE;
                end

                default: begin
                    owner   <= OWN_NONE;
                    bus_as_ <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // A requester stalls until the DONE cycle of its own access.
    always_comb begin
        mem_busy = !mem_as_ && !((state == DONE) && (owner == OWN_MEM));
        if_busy  = !if_req_ && !((state == DONE) && (owner == OWN_IF));
    end

endmodule

// File: tb/tb_bus_arb_ctrl.sv
// tb_bus_arb_ctrl: directed vector table, hand-written corner sequences and
// randomized transactions for bus_arb_ctrl.

module tb_bus_arb_ctrl;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int TMO_W  = 4;
    localparam int TMO    = (1 << TMO_W) - 1;

    logic              clk;
    logic              reset_;
    logic              if_req_;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rd_data;
    logic              if_busy;
    logic              mem_as_;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_busy;
    logic              bus_as_;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;
    logic              bus_err;

    int checks_total;
    int checks_passed;

    // Reference copies of the two read-data registers.
    logic [DATA_W-1:0] model_if_rd;
    logic [DATA_W-1:0] model_mem_rd;

    typedef struct {
        bit                use_mem;
        bit                use_if;
        bit                rw;
        logic [ADDR_W-1:0] maddr;
        logic [DATA_W-1:0] mwdata;
        logic [ADDR_W-1:0] iaddr;
        logic [DATA_W-1:0] rdata;
        int                waits;
        bit                drop;
        bit                exp_mem;
        logic [DATA_W-1:0] exp_rd;
        bit                exp_err;
    } vec_t;

    vec_t tbl[8];

    bus_arb_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TMO_W (TMO_W)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .if_req_    (if_req_),
        .if_addr    (if_addr),
        .if_rd_data (if_rd_data),
        .if_busy    (if_busy),
        .mem_as_    (mem_as_),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .mem_busy   (mem_busy),
        .bus_as_    (bus_as_),
        .bus_rw     (bus_rw),
        .bus_addr   (bus_addr),
        .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data),
        .bus_rdy_   (bus_rdy_),
        .bus_err    (bus_err)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case anything stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " bus_as_"}, bus_as_, 1);
        checkOutput({tag, " bus_rw"}, bus_rw, 1);
        checkOutput({tag, " bus_addr"}, bus_addr, 0);
        checkOutput({tag, " bus_wr_data"}, bus_wr_data, 0);
        checkOutput({tag, " bus_err"}, bus_err, 0);
        checkOutput({tag, " if_rd_data"}, if_rd_data, 0);
        checkOutput({tag, " mem_rd_data"}, mem_rd_data, 0);
    endtask

    // Outcome of one access derived from the arbitration rules alone.
    function automatic void predict(input bit use_mem, input bit rw, input logic [DATA_W-1:0] rdata,
                                    input int waits, output bit own_mem,
                                    output logic [DATA_W-1:0] rd, output bit err);
        own_mem = use_mem;
        err     = (waits >= TMO);
        rd      = (err || (use_mem && !rw)) ? '0 : rdata;
    endfunction

    // Runs one access starting from an IDLE negedge and ending in the next IDLE.
    task automatic applyStimulus(input bit use_mem, input bit use_if, input bit rw,
                                 input logic [ADDR_W-1:0] maddr, input logic [DATA_W-1:0] mwdata,
                                 input logic [ADDR_W-1:0] iaddr, input logic [DATA_W-1:0] rdata,
                                 input int waits, input bit drop, input bit exp_mem,
                                 input logic [DATA_W-1:0] exp_rd, input bit exp_err);
        logic [ADDR_W-1:0] exp_addr;
        bit                exp_rw;
        int                acc_cycles;
        bit                mreq;
        bit                ireq;
        exp_addr   = exp_mem ? maddr : iaddr;
        exp_rw     = exp_mem ? rw : 1'b1;
        acc_cycles = (waits >= TMO) ? TMO : waits + 1;
        mreq       = use_mem;
        ireq       = use_if;

        mem_as_     = !use_mem;
        mem_rw      = rw;
        mem_addr    = maddr;
        mem_wr_data = mwdata;
        if_req_     = !use_if;
        if_addr     = iaddr;
        bus_rdy_    = 1'b1;
        #1;
        checkOutput("idle mem_busy", mem_busy, mreq);
        checkOutput("idle if_busy", if_busy, ireq);
        @(negedge clk);

        for (int k = 1; k <= acc_cycles; k++) begin
            checkOutput("acc bus_as_", bus_as_, 0);
            checkOutput("acc bus_addr", bus_addr, exp_addr);
            checkOutput("acc bus_rw", bus_rw, exp_rw);
            if (!exp_rw) checkOutput("acc bus_wr_data", bus_wr_data, mwdata);
            checkOutput("acc bus_err", bus_err, 0);
            checkOutput("acc mem_busy", mem_busy, mreq);
            checkOutput("acc if_busy", if_busy, ireq);
            if (drop && k == 1) begin
                if (exp_mem) begin
                    mem_as_ = 1'b1;
                    mreq    = 1'b0;
                end else begin
                    if_req_ = 1'b1;
                    ireq    = 1'b0;
                end
            end
            if (k <= waits) begin
                bus_rdy_    = 1'b1;
                bus_rd_data = $urandom;
            end else begin
                bus_rdy_    = 1'b0;
                bus_rd_data = rdata;
            end
            @(negedge clk);
        end

        if (exp_mem) model_mem_rd = exp_rd;
        else         model_if_rd  = exp_rd;
        checkOutput("done bus_as_", bus_as_, 1);
        checkOutput("done bus_err", bus_err, exp_err);
        checkOutput("done mem_rd_data", mem_rd_data, model_mem_rd);
        checkOutput("done if_rd_data", if_rd_data, model_if_rd);
        checkOutput("done mem_busy", mem_busy, mreq && !exp_mem);
        checkOutput("done if_busy", if_busy, ireq && exp_mem);
        mem_as_  = 1'b1;
        if_req_  = 1'b1;
        bus_rdy_ = 1'b1;
        @(negedge clk);
        checkOutput("post bus_err", bus_err, 0);
        checkOutput("post bus_as_", bus_as_, 1);
    endtask

    initial begin
        bit                own_mem;
        logic [DATA_W-1:0] prd;
        bit                perr;
        checks_total  = 0;
        checks_passed = 0;
        model_if_rd   = '0;
        model_mem_rd  = '0;

        tbl[0] = '{0, 1, 1, 30'h0,        32'h0,        30'h10, 32'hDEADBEEF, 0,  0, 0, 32'hDEADBEEF, 0};
        tbl[1] = '{1, 0, 0, 30'h20,       32'h12345678, 30'h0,  32'hAAAA5555, 0,  0, 1, 32'h0,        0};
        tbl[2] = '{1, 0, 1, 30'h3FFFFFFF, 32'h0,        30'h0,  32'hCAFEF00D, 3,  0, 1, 32'hCAFEF00D, 0};
        tbl[3] = '{1, 1, 1, 30'h44,       32'h0,        30'h55, 32'h0BADC0DE, 1,  0, 1, 32'h0BADC0DE, 0};
        tbl[4] = '{0, 1, 1, 30'h0,        32'h0,        30'h64, 32'h13579BDF, 14, 0, 0, 32'h13579BDF, 0};
        tbl[5] = '{1, 0, 1, 30'h88,       32'h0,        30'h0,  32'h55AA55AA, 15, 0, 1, 32'h0,        1};
        tbl[6] = '{0, 1, 1, 30'h0,        32'h0,        30'h9C, 32'h77777777, 20, 1, 0, 32'h0,        1};
        tbl[7] = '{0, 1, 1, 30'h0,        32'h0,        30'hA0, 32'hFFFFFFFF, 0,  1, 0, 32'hFFFFFFFF, 0};

        reset_      = 1'b0;
        if_req_     = 1'b1;
        if_addr     = '0;
        mem_as_     = 1'b1;
        mem_rw      = 1'b1;
        mem_addr    = '0;
        mem_wr_data = '0;
        bus_rd_data = '0;
        bus_rdy_    = 1'b1;
        @(negedge clk);
        checkResetValues("reset");
        checkOutput("reset mem_busy", mem_busy, 0);
        checkOutput("reset if_busy", if_busy, 0);
        reset_ = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].use_mem, tbl[i].use_if, tbl[i].rw, tbl[i].maddr, tbl[i].mwdata,
                          tbl[i].iaddr, tbl[i].rdata, tbl[i].waits, tbl[i].drop,
                          tbl[i].exp_mem, tbl[i].exp_rd, tbl[i].exp_err);
        end

        // Collision: the store wins, the fetch follows after DONE and IDLE.
        mem_as_ = 1'b0; mem_rw = 1'b0; mem_addr = 30'h20; mem_wr_data = 32'h12345678;
        if_req_ = 1'b0; if_addr = 30'h30;
        @(negedge clk);
        checkOutput("col acc bus_as_", bus_as_, 0);
        checkOutput("col acc bus_rw", bus_rw, 0);
        checkOutput("col acc bus_addr", bus_addr, 30'h20);
        checkOutput("col acc bus_wr_data", bus_wr_data, 32'h12345678);
        checkOutput("col acc if_busy", if_busy, 1);
        bus_rdy_ = 1'b0;
        @(negedge clk);
        model_mem_rd = '0;
        checkOutput("col done mem_busy", mem_busy, 0);
        checkOutput("col done if_busy", if_busy, 1);
        checkOutput("col done mem_rd_data", mem_rd_data, 0);
        mem_as_ = 1'b1; bus_rdy_ = 1'b1;
        @(negedge clk);
        checkOutput("col idle bus_as_", bus_as_, 1);
        checkOutput("col idle if_busy", if_busy, 1);
        @(negedge clk);
        checkOutput("col fetch bus_as_", bus_as_, 0);
        checkOutput("col fetch bus_addr", bus_addr, 30'h30);
        checkOutput("col fetch bus_rw", bus_rw, 1);
        bus_rdy_ = 1'b0; bus_rd_data = 32'h600DF00D;
        @(negedge clk);
        model_if_rd = 32'h600DF00D;
        checkOutput("col fetch if_rd_data", if_rd_data, model_if_rd);
        checkOutput("col fetch if_busy", if_busy, 0);
        checkOutput("col fetch mem_rd_data", mem_rd_data, model_mem_rd);
        if_req_ = 1'b1; bus_rdy_ = 1'b1;
        @(negedge clk);

        // Back-to-back fetches with if_req_ held low.
        if_req_ = 1'b0; if_addr = 30'h100;
        @(negedge clk);
        checkOutput("b2b first bus_as_", bus_as_, 0);
        checkOutput("b2b first bus_addr", bus_addr, 30'h100);
        bus_rdy_ = 1'b0; bus_rd_data = 32'h11111111;
        @(negedge clk);
        checkOutput("b2b first done bus_as_", bus_as_, 1);
        checkOutput("b2b first if_rd_data", if_rd_data, 32'h11111111);
        checkOutput("b2b first if_busy", if_busy, 0);
        if_addr = 30'h104; bus_rdy_ = 1'b1;
        @(negedge clk);
        checkOutput("b2b gap bus_as_", bus_as_, 1);
        checkOutput("b2b gap if_busy", if_busy, 1);
        bus_rdy_ = 1'b0; bus_rd_data = 32'h22222222;
        @(negedge clk);
        checkOutput("b2b second bus_as_", bus_as_, 0);
        checkOutput("b2b second bus_addr", bus_addr, 30'h104);
        @(negedge clk);
        model_if_rd = 32'h22222222;
        checkOutput("b2b second if_rd_data", if_rd_data, model_if_rd);
        checkOutput("b2b second if_busy", if_busy, 0);
        if_req_ = 1'b1; bus_rdy_ = 1'b1;
        @(negedge clk);

        // Reset asserted while a load waits for the bus.
        mem_as_ = 1'b0; mem_rw = 1'b1; mem_addr = 30'h77;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst pre bus_as_", bus_as_, 0);
        #2;
        reset_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'h99999999;
        #1;
        checkResetValues("rst async");
        mem_as_ = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst held bus_as_", bus_as_, 1);
        checkOutput("rst held mem_rd_data", mem_rd_data, 0);
        @(negedge clk);
        reset_ = 1'b1; bus_rdy_ = 1'b1;
        model_if_rd = '0; model_mem_rd = '0;
        @(negedge clk);
        checkOutput("rst post bus_as_", bus_as_, 1);

        // Randomized accesses against the reference rules.
        for (int n = 0; n < 40; n++) begin
            int                kind;
            bit                use_mem;
            bit                use_if;
            bit                rw;
            logic [DATA_W-1:0] rdata;
            int                waits;
            kind    = int'($urandom_range(0, 2));
            use_mem = (kind != 0);
            use_if  = (kind != 1);
            rw      = 1'($urandom_range(0, 1));
            rdata   = $urandom;
            waits   = int'($urandom_range(0, 17));
            predict(use_mem, rw, rdata, waits, own_mem, prd, perr);
            applyStimulus(use_mem, use_if, rw, ADDR_W'($urandom), $urandom, ADDR_W'($urandom),
                          rdata, waits, 1'($urandom_range(0, 1)), own_mem, prd, perr);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
